// File: rtl/dopamine_weight_updater_pkg.sv
// nm_plasticity_pkg: shared types and constants for the reward-modulated
// weight updater.
//   state_t    - sweep FSM state encoding
//   syn_word_t - synapse word layout {eligibility (s8), weight (u8)}
//   ELIG_*/W_* - bit positions of the word fields
//   DA_BASE_DEFAULT - dopamine baseline (neither potentiates nor depresses)
package nm_plasticity_pkg;

  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

  localparam int ELIG_MSB = 15;
  localparam int ELIG_LSB = 8;
  localparam int W_MSB    = 7;
  localparam int W_LSB    = 0;

  localparam int DA_BASE_DEFAULT = 112;

  typedef struct packed {
    logic [7:0] elig;
    logic [7:0] w;
  } syn_word_t;

endpackage

// File: rtl/dopamine_weight_updater_if.sv
// Synapse SRAM port bundle.
//   mem_addr_o  - word address
//   mem_rd_o    - read strobe; mem_rdata_i valid next cycle, held until next read
//   mem_wr_o    - write strobe
//   mem_wdata_o - write word {elig, w}
//   mem_rdata_i - read word {elig, w}
// master = weight updater, slave = SRAM.
interface dopamine_weight_updater_if #(
  parameter int AW = 12
);
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_o;
  logic          mem_wr_o;
  logic [15:0]   mem_wdata_o;
  logic [15:0]   mem_rdata_i;

  modport master (
    output mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dopamine_weight_updater_alu.sv
// weight_update_alu: combinational three-factor update for one synapse.
//   da       in  dopamine level latched for the sweep (u8)
//   elig     in  eligibility trace (s8)
//   w        in  current weight (u8)
//   wnew     out clamp(w + ((da - DA_BASE) * elig >>> LR_SHIFT), 0, 255)
//   elig_out out eligibility to write back
// Build option DOPAMINE_ELIG_DECAY_EN: when defined, elig_out decays by a
// quarter (elig - (elig >>> 2)); otherwise elig is written back unchanged.
module weight_update_alu
  import nm_plasticity_pkg::*;
#(
  parameter int DA_BASE  = DA_BASE_DEFAULT,
  parameter int LR_SHIFT = 6
) (
  input  logic [7:0]        da,
  input  logic signed [7:0] elig,
  input  logic [7:0]        w,
  output logic [7:0]        wnew,
  output logic signed [7:0] elig_out
);

  logic signed [8:0]  err;
  logic signed [16:0] prod;
  logic signed [16:0] delta;
  logic signed [17:0] w_ext;
  logic signed [17:0] d_ext;
  logic signed [17:0] sum;

  assign err   = $signed({1'b0, da}) - $signed(9'(DA_BASE));
  assign prod  = err * elig;
  // Arithmetic shift floors toward -inf, so tiny negative products still depress by 1.
  assign delta = prod >>> LR_SHIFT;
  assign w_ext = {10'd0, w};
  assign d_ext = {delta[16], delta};
  assign sum   = w_ext + d_ext;

  always_comb begin
    wnew = sum[7:0];
    if (sum[17]) begin
      wnew = 8'd0;
    end else if (sum > 18'sd255) begin
      wnew = 8'd255;
    end
  end

`ifdef DOPAMINE_ELIG_DECAY_EN
  assign elig_out = elig - (elig >>> 2);
`else
  assign elig_out = elig;
`endif

endmodule

// File: rtl/dopamine_weight_updater.sv
// dopamine_weight_updater: on start, latches dopamine once and sweeps the
// synapse SRAM (read, modulate by eligibility, write back), 3 enabled cycles
// per synapse.
//   clk, rst_n   clock, async active-low reset
//   clk_en       global step enable; nothing advances and no strobe fires when 0
//   start_i      sweep request, sampled in IDLE only
//   abort_i      early termination (READ/CALC: immediate, WRITE: after the write)
//   dopamine_i   dopamine level from the state monitor
//   busy_o       high outside IDLE
//   done_o       one enabled-cycle pulse at normal completion
//   sweep_cnt_o  completed-sweep counter (wraps)
//   mem          SRAM master port (see dopamine_weight_updater_if)
// Build option DOPAMINE_ELIG_DECAY_EN: eligibility decay on write-back
// (implemented in weight_update_alu).
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | read strobe for synapse idx
// CALC  | compute updated word from read data, register it
// WRITE | write strobe for synapse idx, advance or finish
// DONE  | done pulse, count completed sweep
module dopamine_weight_updater
  import nm_plasticity_pkg::*;
#(
  parameter int N_SYN    = 4096,
  parameter int AW       = $clog2(N_SYN),
  parameter int DA_BASE  = DA_BASE_DEFAULT,
  parameter int LR_SHIFT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  dopamine_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] sweep_cnt_o,
  dopamine_weight_updater_if.master mem
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_SYN - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [7:0]    da_q;
  syn_word_t     word_q;
  logic [7:0]    wnew;
  logic [7:0]    elig_out;

  weight_update_alu #(
    .DA_BASE  (DA_BASE),
    .LR_SHIFT (LR_SHIFT)
  ) u_alu (
    .da       (da_q),
    .elig     (mem.mem_rdata_i[ELIG_MSB:ELIG_LSB]),
    .w        (mem.mem_rdata_i[W_MSB:W_LSB]),
    .wnew     (wnew),
    .elig_out (elig_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    busy_o          = (state != IDLE);
    done_o          = 1'b0;
    mem.mem_rd_o    = 1'b0;
    mem.mem_wr_o    = 1'b0;
    mem.mem_addr_o  = idx;
    mem.mem_wdata_o = word_q;
    case (state)
      IDLE:  if (start_i) state_nxt = READ;
      READ: begin
        mem.mem_rd_o = clk_en;
        state_nxt    = abort_i ? IDLE : CALC;
      end
      CALC:  state_nxt = abort_i ? IDLE : WRITE;
      WRITE: begin
        mem.mem_wr_o = clk_en;
        if (abort_i)              state_nxt = IDLE;
        else if (idx == LAST_IDX) state_nxt = DONE;
        else                      state_nxt = READ;
      end
      DONE: begin
        done_o    = clk_en;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      da_q        <= '0;
      word_q      <= '0;
      sweep_cnt_o <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (start_i) begin
          da_q <= dopamine_i;
          idx  <= '0;
        end
        CALC:  word_q <= '{elig: elig_out, w: wnew};
        WRITE: if (!abort_i && idx != LAST_IDX) idx <= idx + AW'(1);
        DONE:  sweep_cnt_o <= sweep_cnt_o + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dopamine_weight_updater.sv
module tb_dopamine_weight_updater;
  localparam int N  = 4;
  localparam int AW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  dopamine_i = 8'd0;
  logic        busy_o, done_o;
  logic [15:0] sweep_cnt_o;

  dopamine_weight_updater_if #(.AW(AW)) mem_if ();

  dopamine_weight_updater #(.N_SYN(N), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .dopamine_i  (dopamine_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sweep_cnt_o (sweep_cnt_o),
    .mem         (mem_if)
  );

  always #5 clk = ~clk;

  logic [15:0] sram [N];
  logic [15:0] init_mem [N];
  logic [15:0] rdata = 16'd0;
  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  logic [AW-1:0] wr_addr_q [$];

  assign mem_if.mem_rdata_i = rdata;

  always @(posedge clk) begin
    if (mem_if.mem_rd_o) rdata <= sram[mem_if.mem_addr_o];
    if (mem_if.mem_wr_o) sram[mem_if.mem_addr_o] <= mem_if.mem_wdata_o;
  end

  always @(negedge clk) begin
    if (mem_if.mem_wr_o) wr_addr_q.push_back(mem_if.mem_addr_o);
    if (done_o) done_seen++;
    if (!clk_en) begin
      checks++;
      if (mem_if.mem_rd_o || mem_if.mem_wr_o || done_o) begin
        errors++;
        $display("FAIL strobe_while_disabled: rd=%0b wr=%0b done=%0b required all 0",
                 mem_if.mem_rd_o, mem_if.mem_wr_o, done_o);
      end
    end
  end

  // Reference model: three-factor rule in plain integer arithmetic.
  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic logic [15:0] ref_word(input int da, input logic [15:0] word);
    logic [7:0] e8;
    int elig, w, wn, eo;
    e8   = word[15:8];
    elig = int'($signed(e8));
    w    = int'(word[7:0]);
    wn   = w + fdiv((da - 112) * elig, 64);
    if (wn < 0)   wn = 0;
    if (wn > 255) wn = 255;
    eo = elig;
`ifdef DOPAMINE_ELIG_DECAY_EN
    eo = elig - fdiv(elig, 4);
`endif
    return {eo[7:0], wn[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all(input logic [15:0] word);
    for (int i = 0; i < N; i++) begin
      sram[i]     <= word;
      init_mem[i] = word;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      sram[i]     <= v;
      init_mem[i] = v;
    end
  endtask

  task automatic chk_mem(input string tag, input int da, input int n_written);
    for (int i = 0; i < N; i++) begin
      logic [15:0] exp;
      exp = (i < n_written) ? ref_word(da, init_mem[i]) : init_mem[i];
      chk($sformatf("%s_mem%0d", tag, i), sram[i], exp);
    end
  endtask

  task automatic run_sweep(input logic [7:0] da, input logic [7:0] mid_da, input bit hold,
                           input bit toggle, output int done_at, output int wall);
    int en_idx;
    bit got;
    dopamine_i = da;
    start_i    = 1'b1;
    clk_en     = 1'b1;
    step();
    start_i = hold;
    en_idx  = 0;
    wall    = 0;
    got     = 1'b0;
    done_at = -1;
    while (!got && wall < 200) begin
      if (toggle) clk_en = ((wall % 2) == 1);
      if (wall == 4) dopamine_i = mid_da;
      @(negedge clk);
      wall++;
      if (clk_en) begin
        en_idx++;
        if (done_o) begin
          got     = 1'b1;
          done_at = en_idx;
        end
      end
      step();
    end
    clk_en = 1'b1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL sweep_timeout: no done_o within %0d cycles", wall);
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < bound) begin
      @(negedge clk);
      if (done_o) got = 1'b1;
      n++;
      step();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no done_o within %0d cycles", tag, bound);
    end
  endtask

  typedef struct {
    logic [7:0] da;
    logic [7:0] elig;
    logic [7:0] w;
    logic [7:0] exp_w;
    logic [7:0] exp_e;
  } vec_t;

  vec_t vt[6];

  initial begin
    int done_at, wall, d0;
    logic [15:0] cnt0;
    logic [7:0]  da_r;
    bit          tg;

`ifdef DOPAMINE_ELIG_DECAY_EN
    vt[0] = '{8'd192, 8'd64,  8'd100, 8'd180, 8'h30};
    vt[1] = '{8'd32,  8'd64,  8'd50,  8'd0,   8'h30};
    vt[2] = '{8'd192, 8'd127, 8'd250, 8'd255, 8'h60};
    vt[3] = '{8'd113, 8'hFF,  8'd10,  8'd9,   8'h00};
    vt[4] = '{8'd112, 8'hB3,  8'd33,  8'd33,  8'hC7};
    vt[5] = '{8'd100, 8'd20,  8'd200, 8'd196, 8'h0F};
`else
    vt[0] = '{8'd192, 8'd64,  8'd100, 8'd180, 8'd64};
    vt[1] = '{8'd32,  8'd64,  8'd50,  8'd0,   8'd64};
    vt[2] = '{8'd192, 8'd127, 8'd250, 8'd255, 8'd127};
    vt[3] = '{8'd113, 8'hFF,  8'd10,  8'd9,   8'hFF};
    vt[4] = '{8'd112, 8'hB3,  8'd33,  8'd33,  8'hB3};
    vt[5] = '{8'd100, 8'd20,  8'd200, 8'd196, 8'd20};
`endif

    // Reset values, with clk_en high so any strobe leak would show.
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_cnt",   sweep_cnt_o, 0);
    chk("rst_rd",    mem_if.mem_rd_o, 0);
    chk("rst_wr",    mem_if.mem_wr_o, 0);
    chk("rst_addr",  mem_if.mem_addr_o, 0);
    chk("rst_wdata", mem_if.mem_wdata_o, 0);
    step();
    rst_n = 1'b1;
    step();

    // Directed vectors: every synapse holds the same word.
    for (int v = 0; v < 6; v++) begin
      fill_all({vt[v].elig, vt[v].w});
      wr_addr_q.delete();
      cnt0 = sweep_cnt_o;
      run_sweep(vt[v].da, vt[v].da, 1'b0, 1'b0, done_at, wall);
      chk($sformatf("vec%0d_done_cycle", v), done_at, 13);
      chk($sformatf("vec%0d_nwrites", v), wr_addr_q.size(), N);
      for (int i = 0; i < wr_addr_q.size() && i < N; i++)
        chk($sformatf("vec%0d_waddr%0d", v, i), wr_addr_q[i], i);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("vec%0d_w%0d", v, i), sram[i][7:0], vt[v].exp_w);
        chk($sformatf("vec%0d_e%0d", v, i), sram[i][15:8], vt[v].exp_e);
      end
      chk($sformatf("vec%0d_cnt", v), sweep_cnt_o, 32'(cnt0 + 16'd1));
    end

    // Random words and dopamine, clk_en toggling on alternate sweeps.
    for (int r = 0; r < 8; r++) begin
      fill_rand();
      da_r = 8'($urandom);
      tg   = (r % 2) == 1;
      run_sweep(da_r, da_r, 1'b0, tg, done_at, wall);
      chk($sformatf("rnd%0d_done_cycle", r), done_at, 13);
      chk($sformatf("rnd%0d_wall", r), wall, tg ? 26 : 13);
      chk_mem($sformatf("rnd%0d", r), da_r, N);
    end

    // start_i held high, dopamine changed mid-sweep.
    fill_rand();
    cnt0 = sweep_cnt_o;
    run_sweep(8'd192, 8'd32, 1'b1, 1'b0, done_at, wall);
    chk("hold_done_cycle", done_at, 13);
    chk_mem("hold1", 192, N);
    for (int i = 0; i < N; i++) init_mem[i] = sram[i];
    @(negedge clk);
    chk("hold_idle_gap_busy", busy_o, 0);
    step();
    start_i = 1'b0;
    @(negedge clk);
    chk("hold_restart_busy", busy_o, 1);
    step();
    wait_done("hold2", 40);
    chk_mem("hold2", 32, N);
    chk("hold_cnt", sweep_cnt_o, 32'(cnt0 + 16'd2));

    // Abort during CALC of idx 2 (enabled cycle 8).
    fill_rand();
    wr_addr_q.delete();
    d0   = done_seen;
    cnt0 = sweep_cnt_o;
    da_r = 8'($urandom);
    dopamine_i = da_r;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (7) step();
    abort_i = 1'b1;
    @(negedge clk);
    chk("abort_calc_busy_before", busy_o, 1);
    step();
    abort_i = 1'b0;
    @(negedge clk);
    chk("abort_calc_busy_after", busy_o, 0);
    repeat (6) step();
    chk("abort_calc_nwrites", wr_addr_q.size(), 2);
    chk_mem("abort_calc", da_r, 2);
    chk("abort_calc_done", done_seen, d0);
    chk("abort_calc_cnt", sweep_cnt_o, cnt0);

    // Abort during WRITE of idx 1 (enabled cycle 6): the write still lands.
    fill_rand();
    wr_addr_q.delete();
    da_r = 8'($urandom);
    dopamine_i = da_r;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (5) step();
    abort_i = 1'b1;
    @(negedge clk);
    chk("abort_wr_strobe", mem_if.mem_wr_o, 1);
    chk("abort_wr_addr", mem_if.mem_addr_o, 1);
    step();
    abort_i = 1'b0;
    @(negedge clk);
    chk("abort_wr_busy_after", busy_o, 0);
    repeat (6) step();
    chk("abort_wr_nwrites", wr_addr_q.size(), 2);
    chk_mem("abort_wr", da_r, 2);
    chk("abort_wr_done", done_seen, d0);
    chk("abort_wr_cnt", sweep_cnt_o, cnt0);

    // Asynchronous reset in the middle of WRITE of idx 1.
    fill_all(16'h4064);
    dopamine_i = 8'd192;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  busy_o, 0);
    chk("mid_rst_wr",    mem_if.mem_wr_o, 0);
    chk("mid_rst_addr",  mem_if.mem_addr_o, 0);
    chk("mid_rst_wdata", mem_if.mem_wdata_o, 0);
    chk("mid_rst_cnt",   sweep_cnt_o, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
